// File: rtl/camera_key_scanner_if.sv
// Camera byte bus and frame-buffer write port shared by the key scanner and its driver.
interface camera_key_scanner_if;
  logic        ov_vs;
  logic        ov_hs;
  logic [7:0]  cam_data;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;

  modport master (output ov_vs, ov_hs, cam_data, input fb_we, fb_addr, fb_data);
  modport slave  (input ov_vs, ov_hs, cam_data, output fb_we, fb_addr, fb_data);
endinterface

// File: rtl/camera_key_scanner.sv
// OV7670 YUV422 front end: grey frame-buffer writes plus per-key finger-change
// accumulation over a lower region of interest, producing key_down once per frame.
module camera_key_scanner #(
  parameter int NUM_KEYS = 39,
  parameter int ROI_Y    = 320,
  parameter int U_LO     = 77,
  parameter int U_HI     = 127,
  parameter int V_LO     = 133,
  parameter int V_HI     = 173,
  parameter int Y_MIN    = 40
) (
  input  logic                  ov_pclk,
  input  logic                  rst,
  camera_key_scanner_if.slave   cam,
  output logic                  ov_rst,
  output logic                  ov_pwdn,
  output logic [NUM_KEYS:0]     key_down
);

  localparam logic [7:0]  U_LO_B = 8'(U_LO);
  localparam logic [7:0]  U_HI_B = 8'(U_HI);
  localparam logic [7:0]  V_LO_B = 8'(V_LO);
  localparam logic [7:0]  V_HI_B = 8'(V_HI);
  localparam logic [7:0]  Y_MIN_B = 8'(Y_MIN);
  localparam logic [15:0] ROI_Y_W = 16'(ROI_Y);
  localparam logic [11:0] LAST_KEY = 12'(NUM_KEYS);

  logic        toggle;
  logic        pv;
  logic [15:0] word;
  logic        vs_prev;
  logic        fd;
  logic [15:0] x;
  logic [15:0] y;
  logic [7:0]  prv_u;
  logic        finger;
  logic        old;
  logic [16:0] map_addr;
  logic        count_en;
  logic signed [31:0] delta;
  logic signed [31:0] cnt [NUM_KEYS+1];
  logic        map_mem [0:(1<<17)-1];

  assign ov_rst  = 1'b1;
  assign ov_pwdn = 1'b0;
  assign fd      = cam.ov_vs & ~vs_prev;

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      toggle  <= 1'b0;
      pv      <= 1'b0;
      word    <= '0;
      vs_prev <= 1'b0;
    end else begin
      pv      <= 1'b0;
      vs_prev <= cam.ov_vs;
      if (!cam.ov_hs) begin
        toggle <= 1'b0;
      end else if (!toggle) begin
        word[15:8] <= cam.cam_data;
        toggle     <= 1'b1;
      end else begin
        word[7:0] <= cam.cam_data;
        toggle    <= 1'b0;
        pv        <= 1'b1;
      end
    end
  end

  // The even-x word is {Y1, V}; U was captured from the preceding odd-x word.
  assign finger   = (prv_u >= U_LO_B) && (prv_u <= U_HI_B) &&
                    (word[7:0] >= V_LO_B) && (word[7:0] <= V_HI_B) &&
                    (word[15:8] >= Y_MIN_B);
  assign map_addr = {y[8:1], x[9:1]};
  assign old      = map_mem[map_addr];
  assign count_en = pv && !x[0] && (x[15:4] <= LAST_KEY) && (y > ROI_Y_W);
  assign delta    = (finger == old) ? 32'sd0 : (finger ? 32'sd1 : -32'sd1);

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      x           <= 16'd639;
      y           <= 16'd0;
      prv_u       <= 8'd0;
      cam.fb_we   <= 1'b0;
      cam.fb_addr <= '0;
      cam.fb_data <= '0;
    end else begin
      cam.fb_we <= 1'b0;
      if (pv) begin
        if (x != 16'd0) begin
          x <= x - 16'd1;
        end else begin
          x <= 16'd639;
          y <= y + 16'd1;
        end
        if (x[0]) begin
          prv_u <= word[7:0];
        end else begin
          cam.fb_we   <= 1'b1;
          cam.fb_addr <= {y[8:2], x[9:2]};
          cam.fb_data <= {3{word[15:13]}};
        end
      end else if (fd) begin
        x <= 16'd639;
        y <= 16'd0;
      end
    end
  end

  // Two rows share each map entry, so odd rows compare against the even row just written.
  always_ff @(posedge ov_pclk) begin
    if (pv && !x[0]) map_mem[map_addr] <= finger;
  end

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      key_down <= '0;
      for (int k = 0; k <= NUM_KEYS; k++) cnt[k] <= 32'sd0;
    end else if (fd) begin
      for (int k = 0; k <= NUM_KEYS; k++) begin
        key_down[k] <= !cnt[k][31] && (cnt[k] > 32'sd15);
        cnt[k]      <= 32'sd0;
      end
    end else if (count_en) begin
      for (int k = 0; k <= NUM_KEYS; k++) begin
        if (x[15:4] == 12'(k)) cnt[k] <= cnt[k] + delta;
      end
    end
  end

endmodule

// File: tb/tb_camera_key_scanner.sv
// Randomised bench for camera_key_scanner: short frames against a pixel-level reference
// model of the finger map, per-key counters and frame-buffer writes.
module tb_camera_key_scanner;
  localparam int NUM_KEYS = 39;
  localparam int ROI_Y    = 1;
  localparam int ROWS     = 5;
  localparam int U_LO = 77, U_HI = 127, V_LO = 133, V_HI = 173, Y_MIN = 40;

  logic              ov_pclk = 1'b0;
  logic              rst = 1'b0;
  logic              ov_rst;
  logic              ov_pwdn;
  logic [NUM_KEYS:0] key_down;

  camera_key_scanner_if bus();

  camera_key_scanner #(.NUM_KEYS(NUM_KEYS), .ROI_Y(ROI_Y)) dut (
    .ov_pclk (ov_pclk),
    .rst     (rst),
    .cam     (bus),
    .ov_rst  (ov_rst),
    .ov_pwdn (ov_pwdn),
    .key_down(key_down)
  );

  always #5 ov_pclk = ~ov_pclk;

  int                compared = 0;
  int                mismatched = 0;
  bit                ref_map [0:131071];
  int                ref_cnt [0:NUM_KEYS];
  logic [NUM_KEYS:0] ref_keys;
  logic [NUM_KEYS:0] key_mask;
  logic [23:0]       fb_q [$];
  int                fb_seen = 0;
  logic [14:0]       last_addr;
  logic [8:0]        last_data;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every frame-buffer strobe is matched against the oldest pixel the model expects.
  always @(negedge ov_pclk) begin
    logic [23:0] e;
    if (rst && bus.fb_we) begin
      fb_seen++;
      last_addr = bus.fb_addr;
      last_data = bus.fb_data;
      if (fb_q.size() == 0) begin
        check_output("fb_spurious", 64'(bus.fb_we), 64'd0);
      end else begin
        e = fb_q.pop_front();
        check_output("fb_addr", 64'(bus.fb_addr), 64'(e[23:9]));
        check_output("fb_data", 64'(bus.fb_data), 64'(e[8:0]));
      end
    end
  end

  function automatic logic [7:0] pick(input int a, input int b, input int c);
    int sel;
    sel = int'($urandom_range(0, 2));
    if (sel == 0) return 8'(a);
    if (sel == 1) return 8'(b);
    return 8'(c);
  endfunction

  task automatic skin_values(output logic [7:0] u, output logic [7:0] v, output logic [7:0] y1);
    u  = pick(U_LO, U_HI, int'($urandom_range(U_LO, U_HI)));
    v  = pick(V_LO, V_HI, int'($urandom_range(V_LO, V_HI)));
    y1 = pick(Y_MIN, 255, int'($urandom_range(Y_MIN, 255)));
  endtask

  task automatic near_miss(inout logic [7:0] u, inout logic [7:0] v, inout logic [7:0] y1);
    case ($urandom_range(0, 4))
      0: u = 8'(U_LO - 1);
      1: u = 8'(U_HI + 1);
      2: v = 8'(V_LO - 1);
      3: v = 8'(V_HI + 1);
      default: y1 = 8'(Y_MIN - 1);
    endcase
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge ov_pclk);
    bus.ov_hs    = 1'b1;
    bus.cam_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ov_pclk);
      bus.ov_hs    = 1'b0;
      bus.cam_data = 8'h00;
    end
  endtask

  // Reference behaviour for one pixel pair at line position xe (the even pixel).
  task automatic apply_stimulus(input int row, input int xe, input logic [7:0] y0,
                                input logic [7:0] u, input logic [7:0] y1, input logic [7:0] v);
    bit finger, old;
    int addr, key;
    finger = (u >= U_LO) && (u <= U_HI) && (v >= V_LO) && (v <= V_HI) && (y1 >= Y_MIN);
    addr   = (row / 2) * 512 + xe / 2;
    old    = ref_map[addr];
    ref_map[addr] = finger;
    key = xe / 16;
    if (key <= NUM_KEYS && row > ROI_Y) ref_cnt[key] += int'(finger) - int'(old);
    fb_q.push_back({15'((row / 4) * 256 + xe / 4), {3{y1[7:5]}}});
    put_byte(y0);
    put_byte(u);
    put_byte(y1);
    put_byte(v);
  endtask

  // Modes: 0 non-skin, 1 skin, 2 skin in key 0 only, 3 skin in rows 0..1, 4 random, 5 fixed test bytes.
  task automatic send_line(input int row, input int mode, input int first);
    for (int p = first; p < 320; p++) begin
      int xe;
      bit skin;
      logic [7:0] y0, u, v, y1;
      xe   = 638 - 2 * p;
      y0   = 8'($urandom);
      skin = (mode == 1) || (mode == 2 && xe < 16) || (mode == 3 && row <= 1);
      y1 = 8'd100; v = 8'd150; u = skin ? 8'd100 : 8'd0;
      if (mode == 4) begin
        if (key_mask[xe / 16]) begin
          skin_values(u, v, y1);
          if ($urandom_range(0, 15) == 0) near_miss(u, v, y1);
        end else begin
          case ($urandom_range(0, 2))
            0: begin u = 8'($urandom); v = 8'($urandom); y1 = 8'($urandom); end
            1: skin_values(u, v, y1);
            default: begin skin_values(u, v, y1); near_miss(u, v, y1); end
          endcase
        end
      end else if (mode == 5) begin
        y0 = 8'd80; u = 8'd40; y1 = 8'd80; v = 8'd150;
      end
      apply_stimulus(row, xe, y0, u, y1, v);
    end
    idle(2);
  endtask

  task automatic send_frame(input int mode);
    for (int r = 0; r < ROWS; r++) send_line(r, mode, 0);
  endtask

  task automatic end_frame(input string tag, input bit compare_keys);
    idle(3);
    @(negedge ov_pclk);
    bus.ov_vs = 1'b1;
    for (int k = 0; k <= NUM_KEYS; k++) begin
      ref_keys[k] = ref_cnt[k] > 15;
      ref_cnt[k]  = 0;
    end
    @(negedge ov_pclk);
    if (compare_keys) check_output(tag, 64'(key_down), 64'(ref_keys));
    @(negedge ov_pclk);
    bus.ov_vs = 1'b0;
  endtask

  initial begin
    bus.ov_vs = 1'b0; bus.ov_hs = 1'b0; bus.cam_data = 8'h00;
    for (int k = 0; k <= NUM_KEYS; k++) ref_cnt[k] = 0;
    repeat (3) @(negedge ov_pclk);
    check_output("reset_key_down", 64'(key_down), 64'd0);
    check_output("reset_fb_we", 64'(bus.fb_we), 64'd0);
    check_output("ov_rst", 64'(ov_rst), 64'd1);
    check_output("ov_pwdn", 64'(ov_pwdn), 64'd0);
    rst = 1'b1;

    // The first frame rewrites every map entry the short frames touch.
    key_mask = NUM_KEYS'($urandom) ^ (NUM_KEYS + 1)'({$urandom, $urandom});
    send_frame(4);        end_frame("kd_prime", 1'b0);
    send_frame(0);        end_frame("kd_nonskin", 1'b1);
    send_frame(1);        end_frame("kd_onset", 1'b1);
    check_output("kd_onset_all", 64'(key_down), 64'({(NUM_KEYS + 1){1'b1}}));

    // Reset mid-line while a frame-buffer write is in flight.
    for (int p = 0; p < 100; p++)
      apply_stimulus(0, 638 - 2 * p, 8'd100, 8'd100, 8'd200, 8'd150);
    idle(1);
    @(negedge ov_pclk);
    rst = 1'b0;
    #1;
    check_output("rst_key_down", 64'(key_down), 64'd0);
    check_output("rst_fb_we", 64'(bus.fb_we), 64'd0);
    fb_q.delete();
    for (int k = 0; k <= NUM_KEYS; k++) ref_cnt[k] = 0;
    repeat (2) @(negedge ov_pclk);
    rst = 1'b1;

    fb_seen = 0;
    apply_stimulus(0, 638, 8'd80, 8'd40, 8'd80, 8'd150);
    idle(3);
    check_output("first_fb_count", 64'(fb_seen), 64'd1);
    check_output("first_fb_addr", 64'(last_addr), 64'd159);
    check_output("first_fb_data", 64'(last_data), 64'h092);
    send_line(0, 5, 1);
    for (int r = 1; r < ROWS; r++) send_line(r, 0, 0);
    end_frame("kd_after_reset", 1'b1);

    send_frame(1);        end_frame("kd_onset2", 1'b1);
    check_output("kd_onset2_all", 64'(key_down), 64'({(NUM_KEYS + 1){1'b1}}));
    send_frame(1);        end_frame("kd_static", 1'b1);
    check_output("kd_static_zero", 64'(key_down), 64'd0);
    send_frame(0);        end_frame("kd_removal", 1'b1);
    check_output("kd_removal_zero", 64'(key_down), 64'd0);
    send_frame(2);        end_frame("kd_single", 1'b1);
    check_output("kd_single_key0", 64'(key_down), 64'd1);
    send_frame(3);        end_frame("kd_above_roi", 1'b1);
    check_output("kd_above_roi_zero", 64'(key_down), 64'd0);
    key_mask = (NUM_KEYS + 1)'({$urandom, $urandom});
    send_frame(4);        end_frame("kd_random", 1'b1);

    idle(4);
    check_output("fb_pending", 64'(fb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
